instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NB_DATA_BUS, 32, instruction word width in bits (multiple of 8).
  N_ADDRESS, 128, instruction memory depth in words.
  NB_ADDRESS, $clog2(N_ADDRESS), word address width.
  HALT_INSTR, 32'hFFFF_FFFF, end-of-program word.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  i_clk  in  1  single clock; all state changes on rising edge.
  i_reset  in  1  synchronous, active-high reset.
  i_start  in  1  one-cycle pulse that begins a program load.
  i_rx_data  in  8  received byte.
  i_rx_valid  in  1  i_rx_data valid this cycle.
  o_rx_ready  out  1  loader accepts a byte this cycle.
  o_w_addr  out  NB_ADDRESS  instruction memory write address.
  o_w_en  out  1  instruction memory write enable.
  o_w_data  out  NB_DATA_BUS  instruction memory write data.
  o_busy  out  1  load in progress.
  o_done  out  1  load finished; held until next i_start or reset.
  o_overflow  out  1  memory filled without HALT_INSTR.
  o_count  out  NB_ADDRESS+1  words written in the current or last load.

Function
REQ-003 The FSM SHALL have the states IDLE, RECV, WRITE and DONE, plus CHECK when the macro in REQ-018 is defined.
REQ-004 IDLE -> RECV on i_start; the address counter, byte counter, o_count and o_overflow SHALL clear on that edge.
REQ-005 o_rx_ready SHALL be 1 only in RECV (and in CHECK); a byte with i_rx_valid=1 while o_rx_ready=0 is discarded.
REQ-006 In RECV, each accepted byte SHALL be shifted into the word MSB-first: the first byte lands in bits [NB_DATA_BUS-1 -: 8].
REQ-007 On the edge accepting the last byte (NB_DATA_BUS/8 bytes), the FSM SHALL go to WRITE.
REQ-008 In WRITE, for exactly one cycle: o_w_en=1, o_w_addr=current address, o_w_data=assembled word. Outputs are registered and change only on rising edges.
REQ-009 On leaving WRITE, the address and o_count SHALL increment by 1.
REQ-010 Exit from WRITE, in priority order: word==HALT_INSTR -> DONE (HALT is written to memory); address==N_ADDRESS-1 -> DONE with o_overflow=1; otherwise -> RECV.
REQ-011 In DONE, o_done=1 and o_busy=0; i_start SHALL restart the load as in REQ-004. i_start is ignored in RECV, WRITE and CHECK.
REQ-012 o_busy SHALL be 1 in RECV, WRITE and CHECK.
REQ-013 Outside WRITE, o_w_en=0; o_w_addr and o_w_data hold their last values.
REQ-014 Latency: last byte accepted at edge N -> o_w_en high from edge N to edge N+1.

Reset
REQ-015 i_reset is sampled on the rising edge of i_clk and SHALL override every other input, including i_start in the same cycle.
REQ-016 Reset values: state IDLE; o_rx_ready, o_w_en, o_busy, o_done, o_overflow = 0; o_w_addr, o_w_data, o_count = 0; byte counter and shift register cleared.
REQ-017 A reset during a load SHALL abandon the load. Words already written stay in memory, and no partial word is written.

Configuration
REQ-018 Macro LOADER_CHECKSUM_EN, when defined: after the HALT write, the FSM SHALL enter CHECK and accept one byte. That byte is compared to the XOR of all program bytes, HALT included. The result drives a 1-bit output o_chk_err (1 = mismatch), registered on entry to DONE and cleared on start/reset.
REQ-019 Without LOADER_CHECKSUM_EN: the CHECK state and o_chk_err port SHALL be absent, and WRITE goes directly to DONE on HALT.

Verification
REQ-020 Bytes 20 01 00 05, then FF FF FF FF, sent after i_start -> writes 0x20010005@0 and 0xFFFFFFFF@1; o_count=2; o_done=1; o_overflow=0.
REQ-021 128 non-HALT words, then more bytes -> 128 writes at addresses 0..127; o_overflow=1, o_done=1; extra bytes ignored with o_rx_ready=0.
REQ-022 i_reset after 2 bytes of word 0, then i_start and a full program -> no write before restart; the first write is at address 0 with the new word.
REQ-023 i_rx_valid held high during the WRITE cycle -> that byte is dropped; the next word assembles only from bytes sent while o_rx_ready=1.
REQ-024 With LOADER_CHECKSUM_EN, program from REQ-020 plus checksum byte 0x24 -> o_chk_err=0; with byte 0x25 -> o_chk_err=1.
REQ-025 i_start in DONE -> o_done=0, o_count=0, and the next write is at address 0.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-serial instruction memory loader: assembles MSB-first words from a byte
// stream and writes them until HALT_INSTR or memory full. Optional LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int                     NB_DATA_BUS = 32,
    parameter int                     N_ADDRESS   = 128,
    parameter int                     NB_ADDRESS  = $clog2(N_ADDRESS),
    parameter logic [NB_DATA_BUS-1:0] HALT_INSTR  = {NB_DATA_BUS{1'b1}}
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_ready,
    output logic [NB_ADDRESS-1:0]  o_w_addr,
    output logic                   o_w_en,
    output logic [NB_DATA_BUS-1:0] o_w_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overflow,
    output logic [NB_ADDRESS:0]    o_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                   o_chk_err
`endif
);

    localparam int N_BYTES = NB_DATA_BUS / 8;
    localparam int NB_BCNT = $clog2(N_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
`ifdef LOADER_CHECKSUM_EN
        ,
        CHECK
`endif
    } state_t;

    state_t                   state, state_next;
    logic [NB_ADDRESS-1:0]    addr;
    logic [NB_BCNT-1:0]       byte_cnt;
    logic [NB_DATA_BUS-9:0]   shift_reg;
    logic [NB_DATA_BUS-1:0]   word_next;
    logic                     last_byte;
    logic                     last_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               chk_acc;
`endif

    assign word_next = {shift_reg, i_rx_data};
    assign last_byte = (byte_cnt == NB_BCNT'(N_BYTES - 1));
    assign last_addr = (addr == NB_ADDRESS'(N_ADDRESS - 1));

`ifdef LOADER_CHECKSUM_EN
    assign o_rx_ready = (state == RECV) || (state == CHECK);
    assign o_busy     = (state == RECV) || (state == WRITE) || (state == CHECK);
`else
    assign o_rx_ready = (state == RECV);
    assign o_busy     = (state == RECV) || (state == WRITE);
`endif
    assign o_done     = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (i_start) state_next = RECV;
            end
            RECV: begin
                if (i_rx_valid && last_byte) state_next = WRITE;
            end
            WRITE: begin
                // HALT wins over the full-memory exit so a HALT in the last slot is not an overflow
                if (o_w_data == HALT_INSTR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end else if (last_addr) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (i_rx_valid) state_next = DONE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            addr       <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            o_w_en     <= 1'b0;
            o_w_addr   <= '0;
            o_w_data   <= '0;
            o_overflow <= 1'b0;
            o_count    <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc    <= '0;
            o_chk_err  <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            o_w_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        addr       <= '0;
                        byte_cnt   <= '0;
                        o_count    <= '0;
                        o_overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc    <= '0;
                        o_chk_err  <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (i_rx_valid) begin
                        shift_reg <= word_next[NB_DATA_BUS-9:0];
`ifdef LOADER_CHECKSUM_EN
                        chk_acc   <= chk_acc ^ i_rx_data;
`endif
                        if (last_byte) begin
                            byte_cnt <= '0;
                            o_w_en   <= 1'b1;
                            o_w_addr <= addr;
                            o_w_data <= word_next;
                        end else begin
                            byte_cnt <= byte_cnt + NB_BCNT'(1);
                        end
                    end
                end
                WRITE: begin
                    addr    <= addr + NB_ADDRESS'(1);
                    o_count <= o_count + (NB_ADDRESS+1)'(1);
                    if ((o_w_data != HALT_INSTR) && last_addr) o_overflow <= 1'b1;
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (i_rx_valid) o_chk_err <= (i_rx_data != chk_acc);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
